// File: rtl/regalu_issue_ctrl.sv
// Issue controller for regalu: decodes 3-operand ALU ops into one-hot A/B/D selects, two stages (RD, WB).
// Latency: accept at edge n -> A/B/S/Cin in cycle n+1 -> Dselect in cycle n+2 (write commits at end of n+2).
// Backpressure: instr_ready drops for one cycle on a read-after-write hazard against RD; RD takes a bubble.
// Ports: clk/reset (sync, active-high); instr_* valid/ready input; Aselect/Bselect/Dselect/S/Cin to regalu;
//        busy while any stage is occupied; issue_count/stall_count only when REGALU_ISSUE_PERF_EN is defined.
// Optional feature macro: REGALU_ISSUE_PERF_EN (saturating accept and hazard-stall counters).
module regalu_issue_ctrl #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [2:0]      instr_op,
    input  logic            instr_cin,
    input  logic [AW-1:0]   instr_ra,
    input  logic [AW-1:0]   instr_rb,
    input  logic [AW-1:0]   instr_rd,
    output logic [NREG-1:0] Aselect,
    output logic [NREG-1:0] Bselect,
    output logic [NREG-1:0] Dselect,
    output logic [2:0]      S,
    output logic            Cin,
    output logic            busy
`ifdef REGALU_ISSUE_PERF_EN
    ,
    output logic [CW-1:0]   issue_count,
    output logic [CW-1:0]   stall_count
`endif
);

    if (NREG != (1 << AW) || CW < 1) begin : g_bad_params
        $error("regalu_issue_ctrl: NREG must equal 2**AW and CW must be positive");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [2:0] OP_RSVD = 3'b111;

    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t        state_q, state_d;
    logic          rd_vld_q, rd_vld_d;
    logic [AW-1:0] rd_ra_q, rd_ra_d;
    logic [AW-1:0] rd_rb_q, rd_rb_d;
    logic [AW-1:0] rd_rd_q, rd_rd_d;
    logic [2:0]    rd_op_q, rd_op_d;
    logic          rd_cin_q, rd_cin_d;
    logic          wb_vld_q, wb_vld_d;
    logic [AW-1:0] wb_rd_q, wb_rd_d;
    logic          hazard;
    logic          accept;

    // A bubble carries register 0 everywhere, so it never hazards and its
    // decoded selects are naturally the R0 one-hot.
    assign hazard      = rd_vld_q && (rd_rd_q != '0) &&
                         ((instr_ra == rd_rd_q) || (instr_rb == rd_rd_q));
    assign instr_ready = ~reset & ~hazard;
    assign accept      = instr_valid & instr_ready;

    always_comb begin
        rd_vld_d = accept;
        rd_ra_d  = '0;
        rd_rb_d  = '0;
        rd_rd_d  = '0;
        rd_op_d  = 3'b000;
        rd_cin_d = 1'b0;
        if (accept) begin
            rd_ra_d  = instr_ra;
            rd_rb_d  = instr_rb;
            rd_rd_d  = instr_rd;
            rd_op_d  = instr_op;
            rd_cin_d = instr_cin;
        end
        // Reserved op still executes but its result is dropped into R0.
        wb_vld_d = rd_vld_q;
        wb_rd_d  = (rd_op_q == OP_RSVD) ? '0 : rd_rd_q;
    end

    always_comb begin
        state_d = state_q;
        if (!rd_vld_d && !wb_vld_d) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (accept) state_d = ST_RUN;
                ST_RUN:   if (hazard) state_d = ST_STALL;
                ST_STALL: if (accept) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rd_vld_q <= 1'b0;
            rd_ra_q  <= '0;
            rd_rb_q  <= '0;
            rd_rd_q  <= '0;
            rd_op_q  <= 3'b000;
            rd_cin_q <= 1'b0;
            wb_vld_q <= 1'b0;
            wb_rd_q  <= '0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_vld_d;
            rd_ra_q  <= rd_ra_d;
            rd_rb_q  <= rd_rb_d;
            rd_rd_q  <= rd_rd_d;
            rd_op_q  <= rd_op_d;
            rd_cin_q <= rd_cin_d;
            wb_vld_q <= wb_vld_d;
            wb_rd_q  <= wb_rd_d;
        end
    end

    assign Aselect = onehot(rd_ra_q);
    assign Bselect = onehot(rd_rb_q);
    assign Dselect = onehot(wb_rd_q);
    assign S       = rd_op_q;
    assign Cin     = rd_cin_q;
    assign busy    = (state_q != ST_IDLE);

`ifdef REGALU_ISSUE_PERF_EN
    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (accept && (issue_cnt_q != '1)) issue_cnt_d = issue_cnt_q + 1'b1;
        if (instr_valid && hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_count = issue_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regalu_issue_ctrl.sv
module tb_regalu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_op = 3'b000;
    logic        instr_cin = 1'b0;
    logic [4:0]  instr_ra = 5'd0;
    logic [4:0]  instr_rb = 5'd0;
    logic [4:0]  instr_rd = 5'd0;
    logic [31:0] Aselect, Bselect, Dselect;
    logic [2:0]  S;
    logic        Cin;
    logic        busy;
`ifdef REGALU_ISSUE_PERF_EN
    logic [15:0] issue_count, stall_count;
`endif

    regalu_issue_ctrl #(.NREG(32), .AW(5), .CW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_cin   (instr_cin),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .instr_rd    (instr_rd),
        .Aselect     (Aselect),
        .Bselect     (Bselect),
        .Dselect     (Dselect),
        .S           (S),
        .Cin         (Cin),
        .busy        (busy)
`ifdef REGALU_ISSUE_PERF_EN
        ,
        .issue_count (issue_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // pcount = number of rising edges seen; values launched by edge E are
    // visible while pcount == E.
    int pcount = 0;
    always @(posedge clk) pcount++;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  s;
        logic        cin;
    } rd_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] d;
    } wb_exp_t;

    rd_exp_t rd_q[$];
    wb_exp_t wb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, pcount);
        end
    endtask

    // Monitor: every cycle the RD and WB outputs must either match the
    // scoreboard entry due now or show bubble values.
    always @(negedge clk) begin
        if (mon_en) begin
            rd_exp_t re;
            wb_exp_t we;
            re = '{cyc: pcount, a: 32'h1, b: 32'h1, s: 3'b000, cin: 1'b0};
            we = '{cyc: pcount, d: 32'h1};
            while (rd_q.size() > 0 && rd_q[0].cyc < pcount) begin
                n_checks++; n_errors++;
                $display("FAIL rd_missed: entry for edge %0d never checked", rd_q[0].cyc);
                void'(rd_q.pop_front());
            end
            while (wb_q.size() > 0 && wb_q[0].cyc < pcount) begin
                n_checks++; n_errors++;
                $display("FAIL wb_missed: entry for edge %0d never checked", wb_q[0].cyc);
                void'(wb_q.pop_front());
            end
            if (rd_q.size() > 0 && rd_q[0].cyc == pcount) re = rd_q.pop_front();
            if (wb_q.size() > 0 && wb_q[0].cyc == pcount) we = wb_q.pop_front();
            chk("Aselect", Aselect, re.a);
            chk("Bselect", Bselect, re.b);
            chk("S", 32'(S), 32'(re.s));
            chk("Cin", 32'(Cin), 32'(re.cin));
            chk("Dselect", Dselect, we.d);
        end
    end

    // Offer one instruction, wait (bounded) for ready, and record the
    // hand-computed expected selects against the accepting edge.
    task automatic issue(input logic [2:0] op, input logic cin,
                         input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ed,
                         output int acc, output int waits);
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op = op; instr_cin = cin;
        instr_ra = ra; instr_rb = rb; instr_rd = rd;
        #1;
        waits = 0;
        while (!instr_ready && waits < 20) begin
            @(negedge clk); #1;
            waits++;
        end
        if (!instr_ready) begin
            n_checks++; n_errors++;
            $display("FAIL ready_timeout: ready=%0b required 1 within 20 cycles", instr_ready);
            instr_valid = 1'b0;
            acc = -1;
        end else begin
            acc = pcount + 1;
            rd_q.push_back('{cyc: acc, a: ea, b: eb, s: op, cin: cin});
            wb_q.push_back('{cyc: acc + 1, d: ed});
            @(posedge clk); #1;
            instr_valid = 1'b0;
        end
    endtask

    // Assert reset for n edges; scoreboard entries that would have appeared
    // after the first reset edge are discarded.
    task automatic pulse_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        #2;
        while (rd_q.size() > 0 && rd_q[$].cyc > pcount) void'(rd_q.pop_back());
        while (wb_q.size() > 0 && wb_q[$].cyc > pcount) void'(wb_q.pop_back());
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, w1, w2;

        // 1: reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_Aselect", Aselect, 32'h00000001);
        chk("rst_Bselect", Bselect, 32'h00000001);
        chk("rst_Dselect", Dselect, 32'h00000001);
        chk("rst_S", 32'(S), 32'h0);
        chk("rst_Cin", 32'(Cin), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ready", 32'(instr_ready), 32'h0);
        mon_en = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(instr_ready), 32'h1);

        // 2: XOR r1 = r0 ^ r0, then drain
        issue(3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h1, 32'h1, 32'h00000002, a1, w1);
        chk("t2_waits", 32'(w1), 32'd0);
        chk("t2_busy_inflight", 32'(busy), 32'h1);
        while (pcount < a1 + 2) @(negedge clk);
        chk("t2_busy_drained", 32'(busy), 32'h0);

        // 3: RAW hazard: consumer of r1 right behind its producer
        pulse_reset(1);
        issue(3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h1, 32'h1, 32'h00000002, a1, w1);
        issue(3'b001, 1'b0, 5'd0, 5'd1, 5'd2, 32'h1, 32'h2, 32'h00000004, a2, w2);
        chk("t3_stall_cycles", 32'(w2), 32'd1);
        chk("t3_accept_edge", 32'(a2 - a1), 32'd2);
        repeat (3) @(negedge clk);
`ifdef REGALU_ISSUE_PERF_EN
        chk("t3_issue_count", 32'(issue_count), 32'd2);
        chk("t3_stall_count", 32'(stall_count), 32'd1);
`endif

        // 4: producer into r0, consumer reads r0: no stall
        issue(3'b010, 1'b0, 5'd3, 5'd4, 5'd0, 32'h8, 32'h10, 32'h1, a1, w1);
        issue(3'b011, 1'b1, 5'd0, 5'd0, 5'd6, 32'h1, 32'h1, 32'h40, a2, w2);
        chk("t4_waits", 32'(w2), 32'd0);
        chk("t4_back_to_back", 32'(a2 - a1), 32'd1);

        // top register boundary, back-to-back with the previous one
        issue(3'b100, 1'b1, 5'd31, 5'd30, 5'd31, 32'h80000000, 32'h40000000, 32'h80000000, a1, w1);
        chk("t4b_waits", 32'(w1), 32'd0);

        // 5: reserved op executes but writes only R0 (follows a writer of r31: no conflict)
        issue(3'b111, 1'b1, 5'd8, 5'd4, 5'd5, 32'h100, 32'h10, 32'h1, a1, w1);
        chk("t5_waits", 32'(w1), 32'd0);
        repeat (3) @(negedge clk);

        // 6: reset with two instructions in flight
        issue(3'b010, 1'b0, 5'd1, 5'd2, 5'd3, 32'h2, 32'h4, 32'h8, a1, w1);
        issue(3'b011, 1'b0, 5'd5, 5'd6, 5'd4, 32'h20, 32'h40, 32'h10, a2, w2);
        chk("t6_busy_before", 32'(busy), 32'h1);
        pulse_reset(1);
        @(negedge clk);
        chk("t6_Dselect_after", Dselect, 32'h1);
        chk("t6_busy_after", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);

        begin
            int guard;
            guard = 0;
            while ((rd_q.size() > 0 || wb_q.size() > 0) && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (rd_q.size() > 0 || wb_q.size() > 0) begin
                n_checks++; n_errors++;
                $display("FAIL drain: %0d rd and %0d wb entries left, required 0", rd_q.size(), wb_q.size());
            end
        end
        @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
